// File: rtl/bsg_gateway_iodelay_ctrl_pkg.sv
// bsg_gateway_iodelay_ctrl_pkg: shared types for the gateway IODELAY
// tap controller (controller states and default tap width).
package bsg_gateway_iodelay_ctrl_pkg;

    localparam int tap_width_gp = 8;

    typedef enum logic [2:0] {
        e_reset,
        e_init,
        e_idle,
        e_step,
        e_settle
    } iodelay_state_e;

endpackage

// File: rtl/bsg_gateway_iodelay_ctrl_tap_file.sv
// bsg_gateway_iodelay_ctrl_tap_file: per-lane current-tap registers.
// Readback port exists only with BSG_GATEWAY_IODELAY_CTRL_READBACK_EN.
module bsg_gateway_iodelay_ctrl_tap_file
    import bsg_gateway_iodelay_ctrl_pkg::*;
#(
    parameter int lanes_p     = 41,
    parameter int tap_width_p = tap_width_gp,
    parameter int max_tap_p   = 255,
    localparam int lane_w_lp  = $clog2(lanes_p)
) (
    input  logic                   clk_i,
    input  logic                   clear_i,
    input  logic                   step_v_i,
    input  logic                   step_inc_i,
    input  logic [lane_w_lp-1:0]   step_lane_i,
    input  logic [lane_w_lp-1:0]   cur_lane_i,
    output logic [tap_width_p-1:0] cur_tap_o
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
    ,
    input  logic [lane_w_lp-1:0]   rd_lane_i,
    output logic [tap_width_p-1:0] rd_tap_o
`endif
);

    localparam logic [tap_width_p-1:0] max_lp =
        tap_width_p'(max_tap_p);

    logic [tap_width_p-1:0] tap_r [lanes_p];
    logic [tap_width_p-1:0] step_tap;
    logic                   step_ok;

    assign step_ok  = int'(step_lane_i) < lanes_p;
    assign step_tap = step_ok ? tap_r[step_lane_i] : '0;

    // Saturate at both ends so the registers never leave [0, max_tap_p].
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            for (int i = 0; i < lanes_p; i++) begin
                tap_r[i] <= '0;
            end
        end else if (step_v_i && step_ok) begin
            if (step_inc_i && step_tap != max_lp) begin
                tap_r[step_lane_i] <= step_tap + 1'b1;
            end else if (!step_inc_i && step_tap != '0) begin
                tap_r[step_lane_i] <= step_tap - 1'b1;
            end
        end
    end

    assign cur_tap_o = (int'(cur_lane_i) < lanes_p)
                     ? tap_r[cur_lane_i] : '0;

`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
    assign rd_tap_o = (int'(rd_lane_i) < lanes_p)
                    ? tap_r[rd_lane_i] : '0;
`endif

endmodule

// File: rtl/bsg_gateway_iodelay_ctrl.sv
// bsg_gateway_iodelay_ctrl: walks per-lane IODELAY taps to commanded targets.
// Define BSG_GATEWAY_IODELAY_CTRL_READBACK_EN for the rd_lane_i/rd_tap_o port.
module bsg_gateway_iodelay_ctrl
    import bsg_gateway_iodelay_ctrl_pkg::*;
#(
    parameter int lanes_p         = 41,
    parameter int tap_width_p     = tap_width_gp,
    parameter int max_tap_p       = 255,
    parameter int init_tap_p      = 0,
    parameter int settle_cycles_p = 4,
    localparam int lane_w_lp      = $clog2(lanes_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cfg_v_i,
    input  logic [lane_w_lp-1:0]   cfg_lane_i,
    input  logic [tap_width_p-1:0] cfg_tap_i,
    output logic                   cfg_ready_o,
    output logic                   err_o,
    output logic                   busy_o,
    output logic                   dly_rst_o,
    output logic [lanes_p-1:0]     dly_ce_o,
    output logic                   dly_inc_o
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
    ,
    input  logic [lane_w_lp-1:0]   rd_lane_i,
    output logic [tap_width_p-1:0] rd_tap_o
`endif
);

    localparam int settle_w_lp = $clog2(settle_cycles_p + 1);

    localparam logic [tap_width_p-1:0] max_lp =
        tap_width_p'(max_tap_p);
    localparam logic [tap_width_p-1:0] init_tgt_lp =
        tap_width_p'((init_tap_p < max_tap_p) ? init_tap_p : max_tap_p);
    localparam logic [lane_w_lp-1:0] last_lane_lp =
        lane_w_lp'(lanes_p - 1);
    localparam logic [settle_w_lp-1:0] settle_last_lp =
        settle_w_lp'(settle_cycles_p - 1);

    iodelay_state_e state_r, state_n;

    logic [lane_w_lp-1:0]   lane_r, lane_n, sel_lane;
    logic [tap_width_p-1:0] tgt_r, tgt_n, cfg_tgt, cur_tap;
    logic [settle_w_lp-1:0] settle_r, settle_n;
    logic                   init_r, init_n;
    logic                   err_n, inc_n, cfg_hs, lane_ok;
    logic [lanes_p-1:0]     ce_n;

    // One read port serves both the IDLE compare and the walk decision.
    assign sel_lane = (state_r == e_idle) ? cfg_lane_i : lane_r;
    assign cfg_tgt  = (cfg_tap_i > max_lp) ? max_lp : cfg_tap_i;
    assign lane_ok  = int'(cfg_lane_i) < lanes_p;
    assign cfg_hs   = cfg_v_i && cfg_ready_o;

    bsg_gateway_iodelay_ctrl_tap_file #(
        .lanes_p     (lanes_p),
        .tap_width_p (tap_width_p),
        .max_tap_p   (max_tap_p)
    ) tap_file (
        .clk_i       (clk_i),
        .clear_i     (reset_i),
        .step_v_i    (state_r == e_step),
        .step_inc_i  (dly_inc_o),
        .step_lane_i (lane_r),
        .cur_lane_i  (sel_lane),
        .cur_tap_o   (cur_tap)
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
        ,
        .rd_lane_i   (rd_lane_i),
        .rd_tap_o    (rd_tap_o)
`endif
    );

    always_comb begin
        state_n  = state_r;
        lane_n   = lane_r;
        tgt_n    = tgt_r;
        init_n   = init_r;
        settle_n = settle_r;
        err_n    = 1'b0;
        unique case (state_r)
            e_reset: begin
                lane_n  = '0;
                tgt_n   = init_tgt_lp;
                init_n  = (init_tgt_lp != '0);
                state_n = (init_tgt_lp != '0) ? e_init : e_idle;
            end
            e_init: begin
                state_n = e_step;
            end
            e_idle: begin
                if (cfg_hs) begin
                    if (!lane_ok) begin
                        err_n = 1'b1;
                    end else if (cfg_tgt != cur_tap) begin
                        lane_n  = cfg_lane_i;
                        tgt_n   = cfg_tgt;
                        init_n  = 1'b0;
                        state_n = e_step;
                    end
                end
            end
            e_step: begin
                settle_n = '0;
                state_n  = e_settle;
            end
            e_settle: begin
                if (settle_r != settle_last_lp) begin
                    settle_n = settle_r + 1'b1;
                end else if (cur_tap != tgt_r) begin
                    state_n = e_step;
                end else if (init_r && lane_r != last_lane_lp) begin
                    lane_n  = lane_r + 1'b1;
                    state_n = e_step;
                end else begin
                    init_n  = 1'b0;
                    state_n = e_idle;
                end
            end
            default: begin
                state_n = e_reset;
            end
        endcase
        if (reset_i) begin
            state_n = e_reset;
            err_n   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ce_n = '0;
        if (state_n == e_step) begin
            ce_n[lane_n] = 1'b1;
        end
    end

    assign inc_n = (state_n == e_step) && (init_n || tgt_n > cur_tap);

    always_ff @(posedge clk_i) begin
        state_r     <= state_n;
        lane_r      <= lane_n;
        tgt_r       <= tgt_n;
        init_r      <= init_n;
        settle_r    <= settle_n;
        cfg_ready_o <= (state_n == e_idle);
        busy_o      <= (state_n != e_idle);
        dly_rst_o   <= (state_n == e_reset);
        err_o       <= err_n;
        dly_ce_o    <= ce_n;
        dly_inc_o   <= inc_n;
    end

endmodule

// File: tb/tb_bsg_gateway_iodelay_ctrl.sv
// tb_bsg_gateway_iodelay_ctrl: directed vectors for the IODELAY controller.
// Delay-element taps are rebuilt from the dly_rst/dly_ce/dly_inc outputs.
module tb_bsg_gateway_iodelay_ctrl;

    localparam int lanes_lp  = 41;
    localparam int tap_w_lp  = 9;
    localparam int max_lp    = 255;
    localparam int init_lp   = 2;
    localparam int settle_lp = 4;
    localparam int gap_lp    = 1 + settle_lp;
    localparam int init_len  = lanes_lp * init_lp * gap_lp + 1;

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  cfg_v_i = 1'b0;
    logic [5:0]            cfg_lane_i = '0;
    logic [tap_w_lp-1:0]   cfg_tap_i = '0;
    logic                  cfg_ready_o, err_o, busy_o;
    logic                  dly_rst_o, dly_inc_o;
    logic [lanes_lp-1:0]   dly_ce_o;
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
    logic [5:0]            rd_lane_i = '0;
    logic [tap_w_lp-1:0]   rd_tap_o;
`endif

    bsg_gateway_iodelay_ctrl #(
        .lanes_p         (lanes_lp),
        .tap_width_p     (tap_w_lp),
        .max_tap_p       (max_lp),
        .init_tap_p      (init_lp),
        .settle_cycles_p (settle_lp)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .cfg_v_i     (cfg_v_i),
        .cfg_lane_i  (cfg_lane_i),
        .cfg_tap_i   (cfg_tap_i),
        .cfg_ready_o (cfg_ready_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .dly_rst_o   (dly_rst_o),
        .dly_ce_o    (dly_ce_o),
        .dly_inc_o   (dly_inc_o)
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
        ,
        .rd_lane_i   (rd_lane_i),
        .rd_tap_o    (rd_tap_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int tap_m [lanes_lp];
    int err_cnt = 0;
    int onehot_bad = 0;
    int p_cyc[$];
    int p_lane[$];
    int p_inc[$];

    always @(negedge clk) begin
        if (dly_rst_o) begin
            for (int i = 0; i < lanes_lp; i++) tap_m[i] = 0;
        end
        if (err_o) err_cnt++;
        if (|dly_ce_o) begin
            if ($countones(dly_ce_o) != 1) onehot_bad++;
            for (int i = 0; i < lanes_lp; i++) begin
                if (dly_ce_o[i]) begin
                    tap_m[i] += dly_inc_o ? 1 : -1;
                    p_cyc.push_back(cyc);
                    p_lane.push_back(i);
                    p_inc.push_back(int'(dly_inc_o));
                end
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_pulses();
        p_cyc.delete();
        p_lane.delete();
        p_inc.delete();
    endtask

    task automatic send(input int lane, input int tap, output int acc);
        cfg_v_i    = 1'b1;
        cfg_lane_i = 6'(lane);
        cfg_tap_i  = tap_w_lp'(tap);
        acc = cyc + 1;
        @(negedge clk);
        cfg_v_i = 1'b0;
    endtask

    task automatic wait_ready(input int ref_cyc, output int off);
        int n = 0;
        while (!cfg_ready_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        off = cfg_ready_o ? cyc - ref_cyc : -1;
    endtask

    task automatic check_walk(input string tag, input int n,
                              input int lane, input int inc,
                              input int acc);
        int bad = 0;
        chk({tag, "_npulse"}, p_cyc.size(), n);
        for (int i = 0; i < p_cyc.size(); i++) begin
            if (p_lane[i] != lane || p_inc[i] != inc) bad++;
            if (i > 0 && p_cyc[i] - p_cyc[i-1] != gap_lp) bad++;
        end
        chk({tag, "_lane_dir_gap"}, bad, 0);
        if (p_cyc.size() > 0) chk({tag, "_first"}, p_cyc[0] - acc, 0);
    endtask

`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
    task automatic rb(input int lane, input int exp);
        rd_lane_i = 6'(lane);
        #1;
        chk("readback", int'(rd_tap_o), exp);
    endtask
`endif

    int acc, off, rel, bad, e0;
    int bl[3] = '{5, 7, 8};
    int bt[3] = '{1, 2, 2};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dly_rst", dly_rst_o, 1);
        chk("rst_ready", cfg_ready_o, 0);
        chk("rst_busy", busy_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_ce", $countones(dly_ce_o), 0);
        chk("rst_inc", dly_inc_o, 0);

        // Post-reset walk of every lane to init_lp.
        clr_pulses();
        reset_i = 1'b0;
        rel = cyc + 1;
        @(negedge clk);
        chk("init_dly_rst", dly_rst_o, 0);
        chk("init_busy", busy_o, 1);
        wait_ready(rel, off);
        chk("init_len", off, init_len);
        chk("init_npulse", p_cyc.size(), lanes_lp * init_lp);
        bad = 0;
        for (int i = 0; i < p_cyc.size(); i++) begin
            if (p_lane[i] != i / init_lp || p_inc[i] != 1) bad++;
            if (i > 0 && p_cyc[i] - p_cyc[i-1] != gap_lp) bad++;
        end
        chk("init_lane_dir_gap", bad, 0);
        if (p_cyc.size() > 0) chk("init_first", p_cyc[0] - rel, 1);
        bad = 0;
        for (int i = 0; i < lanes_lp; i++) if (tap_m[i] != init_lp) bad++;
        chk("init_taps", bad, 0);

        // Lane 5: 2 -> 5, three increments.
        clr_pulses();
        send(5, 5, acc);
        wait_ready(acc, off);
        chk("up_ready", off, 3 * gap_lp);
        check_walk("up", 3, 5, 1, acc);
        chk("up_tap", tap_m[5], 5);
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
        rb(5, 5);
`endif

        // Lane 5: 5 -> 1, four decrements.
        clr_pulses();
        send(5, 1, acc);
        wait_ready(acc, off);
        chk("dn_ready", off, 4 * gap_lp);
        check_walk("dn", 4, 5, 0, acc);
        chk("dn_tap", tap_m[5], 1);
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
        rb(5, 1);
        rb(41, 0);
`endif

        // Zero-distance commands back to back.
        clr_pulses();
        cfg_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg_lane_i = 6'(bl[i]);
            cfg_tap_i  = tap_w_lp'(bt[i]);
            @(negedge clk);
            chk("b2b_ready", cfg_ready_o, 1);
        end
        cfg_v_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_npulse", p_cyc.size(), 0);

        // Target above max_tap_p clamps: lane 0 walks 2 -> 255.
        clr_pulses();
        send(0, 300, acc);
        wait_ready(acc, off);
        chk("clamp_ready", off, (max_lp - init_lp) * gap_lp);
        check_walk("clamp", max_lp - init_lp, 0, 1, acc);
        chk("clamp_tap", tap_m[0], max_lp);
        clr_pulses();
        send(0, 511, acc);
        chk("clamp_eq_ready", cfg_ready_o, 1);
        repeat (6) @(negedge clk);
        chk("clamp_eq_npulse", p_cyc.size(), 0);

        // Out-of-range lanes raise err_o and touch nothing.
        clr_pulses();
        e0 = err_cnt;
        send(41, 7, acc);
        chk("err_pulse", err_o, 1);
        @(negedge clk);
        chk("err_clear", err_o, 0);
        send(63, 0, acc);
        repeat (6) @(negedge clk);
        chk("err_count", err_cnt - e0, 2);
        chk("err_npulse", p_cyc.size(), 0);
        chk("err_tap40", tap_m[40], init_lp);
        chk("err_ready", cfg_ready_o, 1);

        // Reset in the middle of a 10-step walk on lane 3.
        clr_pulses();
        send(3, 12, acc);
        while (cyc < acc + 4 * gap_lp + settle_lp) @(negedge clk);
        chk("mid_npulse", p_cyc.size(), 5);
        reset_i = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_ce", $countones(dly_ce_o), 0);
        chk("mid_dly_rst", dly_rst_o, 1);
        chk("mid_ready", cfg_ready_o, 0);
        chk("mid_tap3", tap_m[3], 0);
`ifdef BSG_GATEWAY_IODELAY_CTRL_READBACK_EN
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < lanes_lp; i++) begin
            rd_lane_i = 6'(i);
            #1;
            if (rd_tap_o != '0) bad++;
        end
        chk("mid_rd_zero", bad, 0);
`endif
        @(negedge clk);
        clr_pulses();
        reset_i = 1'b0;
        rel = cyc + 1;
        @(negedge clk);
        wait_ready(rel, off);
        chk("reinit_len", off, init_len);
        chk("reinit_npulse", p_cyc.size(), lanes_lp * init_lp);
        chk("reinit_tap3", tap_m[3], init_lp);
        chk("onehot", onehot_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
